isi_frame_capture: RTL

//  Image-sensor-interface (ISI) capture stage feeding the accelerator datapath.
//  On a start pulse it requests a frame from the sensor, stores NUM_PIX pixels into
//  an internal buffer and pulses out_ISI_finished, which launches the accelerator.

---
 rtl/isi_frame_capture.sv | 134 +++++++++++++
 1 files changed

// File: rtl/isi_frame_capture.sv
// isi_frame_capture: image-sensor capture stage.
// On a start pulse it raises the frame request, stores NUM_PIX strobed pixels
// into an internal buffer and pulses out_ISI_finished for one cycle.
// Two independent registered read ports: processor readback and accelerator fetch.
// Optional feature macro: ISI_TIMEOUT_EN enables a strobe watchdog that aborts a
// stalled capture and raises the sticky out_error flag.
module isi_frame_capture #(
  parameter int PIX_W       = 9,
  parameter int NUM_PIX     = 64,
  parameter int ADDR_W      = 6,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic              in_clk,
  input  logic              in_rst,
  input  logic              in_ISI_start,
  input  logic              in_img_sensor_done,
  input  logic [PIX_W-1:0]  in_ISI_data_read,
  output logic              out_frame_capture,
  output logic              out_ISI_finished,
  input  logic [ADDR_W-1:0] in_proc_addr,
  output logic [PIX_W-1:0]  out_proc_data,
  input  logic [ADDR_W-1:0] in_acc_addr,
  output logic [PIX_W-1:0]  out_acc_data,
  output logic              out_busy,
  output logic              out_error
);

  typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_FINISH} state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [PIX_W-1:0]  r_buf [NUM_PIX];

  logic w_wr_en;
  logic w_last;
  logic w_timeout;

  assign w_wr_en = (r_state == S_CAPTURE) && in_img_sensor_done;
  assign w_last  = (r_wr_ptr == ADDR_W'(NUM_PIX - 1));

`ifdef ISI_TIMEOUT_EN
  localparam int WD_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  logic [WD_W-1:0] r_wd;
  logic            r_error;

  // Count consecutive strobe-less capture cycles; expiry aborts the frame.
  assign w_timeout = (r_state == S_CAPTURE) && !in_img_sensor_done &&
                     (r_wd == WD_W'(TIMEOUT_CYC - 1));

  // Watchdog counter and sticky error flag, cleared by an accepted start.
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      r_wd    <= '0;
      r_error <= 1'b0;
    end else if (r_state == S_IDLE && in_ISI_start) begin
      r_wd    <= '0;
      r_error <= 1'b0;
    end else if (r_state == S_CAPTURE) begin
      if (in_img_sensor_done || w_timeout) r_wd <= '0;
      else                                 r_wd <= r_wd + WD_W'(1);
      if (w_timeout) r_error <= 1'b1;
    end else begin
      r_wd <= '0;
    end
  end

  assign out_error = r_error;
`else
  assign w_timeout = 1'b0;
  assign out_error = 1'b0;
`endif

  // Capture FSM with registered control outputs.
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      r_state           <= S_IDLE;
      r_wr_ptr          <= '0;
      out_frame_capture <= 1'b0;
      out_ISI_finished  <= 1'b0;
      out_busy          <= 1'b0;
    end else begin
      out_ISI_finished <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (in_ISI_start) begin
            r_state           <= S_CAPTURE;
            r_wr_ptr          <= '0;
            out_frame_capture <= 1'b1;
            out_busy          <= 1'b1;
          end
        end
        S_CAPTURE: begin
          if (in_img_sensor_done) begin
            r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
            if (w_last) begin
              // Last word: finished is high during the FINISH cycle.
              r_state           <= S_FINISH;
              out_frame_capture <= 1'b0;
              out_busy          <= 1'b0;
              out_ISI_finished  <= 1'b1;
            end
          end else if (w_timeout) begin
            r_state           <= S_IDLE;
            out_frame_capture <= 1'b0;
            out_busy          <= 1'b0;
          end
        end
        S_FINISH: r_state <= S_IDLE;
        default:  r_state <= S_IDLE;
      endcase
    end
  end

  // Pixel buffer; reset clears every word so a fresh frame reads back zeros.
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      for (int i = 0; i < NUM_PIX; i++) r_buf[i] <= '0;
    end else if (w_wr_en) begin
      r_buf[r_wr_ptr] <= in_ISI_data_read;
    end
  end

  // Registered read ports; same-cycle write is not visible (read-before-write).
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      out_proc_data <= '0;
      out_acc_data  <= '0;
    end else begin
      out_proc_data <= r_buf[in_proc_addr];
      out_acc_data  <= r_buf[in_acc_addr];
    end
  end

endmodule
